// File: rtl/draw_seq_pkg.sv
// Shared types and constants for the VGA draw sequencer.
// Holds the FSM state encoding, the 3-bit colour type, named colours and
// the default watchdog timeout (one full 160x120 scan plus slack).
package draw_seq_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLR_RUN  = 3'd1,
      DRAW_RUN = 3'd2,
      FLUSH    = 3'd3,
      ERR      = 3'd4
   } state_t;

   typedef logic [2:0] color_t;

   localparam color_t BLACK   = 3'b000;
   localparam color_t BLUE    = 3'b001;
   localparam color_t GREEN   = 3'b010;
   localparam color_t CYAN    = 3'b011;
   localparam color_t RED     = 3'b100;
   localparam color_t MAGENTA = 3'b101;
   localparam color_t YELLOW  = 3'b110;
   localparam color_t WHITE   = 3'b111;

   localparam int unsigned DEFAULT_TIMEOUT = 160 * 120 + 16;

   // True while a scan is actively plotting pixels.
   function automatic logic is_run(input state_t s);
      return (s == CLR_RUN) || (s == DRAW_RUN);
   endfunction

endpackage

// File: rtl/draw_seq_wdog.sv
// Scan watchdog counter for draw_sequencer.
// Cleared on each grant, counts RUN cycles, and flags the RUN cycle in
// which the TIMEOUT-th pixel is being plotted. Only instantiated when
// DRAW_SEQ_WATCHDOG_EN is defined.
module draw_seq_wdog
   import draw_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Count completed RUN cycles since the most recent grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   // This RUN cycle is the TIMEOUT-th one; the FSM decides whether f saves it.
   assign expire = inc && (cnt == LAST);

endmodule

// File: rtl/draw_sequencer.sv
// Controller for the VGA drawing datapath.
// Arbitrates clear (fixed priority) against draw requests, runs one scan,
// flushes for a cycle while acknowledging, then returns to IDLE.
// Outputs are decoded purely from state and registered data (Moore).
// Optional scan watchdog: define DRAW_SEQ_WATCHDOG_EN.
module draw_sequencer
   import draw_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
   parameter color_t      CLR_COLOR = BLACK
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr_req,
   input  logic       draw_req,
   input  logic [2:0] draw_color,
   input  logic       f,
   output logic       en_counter,
   output logic       s_color,
   output logic [2:0] pix_color,
   output logic       plot,
   output logic       clr_ack,
   output logic       draw_ack,
   output logic       busy,
   output logic       err
);

   state_t state;
   state_t state_nxt;
   color_t color_q;
   logic   scan_clr_q;
   logic   running;
   logic   grant_clr;
   logic   grant_draw;
   logic   wd_expire;

   assign running    = is_run(state);
   assign grant_clr  = (state == IDLE) && clr_req;
   assign grant_draw = (state == IDLE) && !clr_req && draw_req;

`ifdef DRAW_SEQ_WATCHDOG_EN
   draw_seq_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (grant_clr || grant_draw),
      .inc    (running),
      .expire (wd_expire)
   );
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign wd_expire      = 1'b0;
`endif

   // State register; reset drops straight back to IDLE with no ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch which scan was granted and its colour so mid-scan input changes are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         color_q    <= BLACK;
         scan_clr_q <= 1'b0;
      end else if (grant_clr) begin
         scan_clr_q <= 1'b1;
      end else if (grant_draw) begin
         scan_clr_q <= 1'b0;
         color_q    <= draw_color;
      end
   end

   // Next-state selection and Moore output decode.
   always_comb begin
      state_nxt  = state;
      en_counter = 1'b0;
      s_color    = 1'b0;
      pix_color  = BLACK;
      plot       = 1'b0;
      clr_ack    = 1'b0;
      draw_ack   = 1'b0;
      busy       = (state != IDLE);
      err        = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLR_RUN;
            end else if (draw_req) begin
               state_nxt = DRAW_RUN;
            end
         end
         CLR_RUN: begin
            en_counter = 1'b1;
            plot       = 1'b1;
            pix_color  = CLR_COLOR;
            // f wins over a simultaneous timeout: the last pixel completes normally.
            if (f) begin
               state_nxt = FLUSH;
            end else if (wd_expire) begin
               state_nxt = ERR;
            end
         end
         DRAW_RUN: begin
            en_counter = 1'b1;
            plot       = 1'b1;
            s_color    = 1'b1;
            pix_color  = color_q;
            if (f) begin
               state_nxt = FLUSH;
            end else if (wd_expire) begin
               state_nxt = ERR;
            end
         end
         FLUSH: begin
            clr_ack   = scan_clr_q;
            draw_ack  = !scan_clr_q;
            state_nxt = IDLE;
         end
         ERR: begin
            err       = 1'b1;
            state_nxt = ERR;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
